// File: rtl/vga_timing_gen_if.sv
// Monitor-side bundle between vga_timing_gen (master) and its consumers (slave):
// raster coordinates, display enable, console colour return and the registered VGA pins.
interface vga_timing_gen_if;
    localparam int unsigned H_W = 11;
    localparam int unsigned V_W = 10;
    localparam int unsigned C_W = 4;

    logic [H_W-1:0] o_h_coord;
    logic [V_W-1:0] o_v_coord;
    logic           o_disp_enbl;
    logic           o_frame_start;
    logic [C_W-1:0] i_red;
    logic [C_W-1:0] i_green;
    logic [C_W-1:0] i_blue;
    logic [C_W-1:0] o_vga_r;
    logic [C_W-1:0] o_vga_g;
    logic [C_W-1:0] o_vga_b;
    logic           o_vga_hs;
    logic           o_vga_vs;

    modport master (
        output o_h_coord, o_v_coord, o_disp_enbl, o_frame_start,
        input  i_red, i_green, i_blue,
        output o_vga_r, o_vga_g, o_vga_b, o_vga_hs, o_vga_vs
    );

    modport slave (
        input  o_h_coord, o_v_coord, o_disp_enbl, o_frame_start,
        output i_red, i_green, i_blue,
        input  o_vga_r, o_vga_g, o_vga_b, o_vga_hs, o_vga_vs
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 800x600 VGA raster timing generator with blanked, registered colour/sync pins.
// Optional VGA_PIXEL_DIV2_EN: pixel tick every 2nd clk for a 100 MHz board clock.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 56,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 37,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    parameter bit          SYNC_POL = 1'b1
) (
    input logic            clk,
    input logic            arst,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_W     = 11;
    localparam int unsigned V_W     = 10;
    localparam int unsigned C_W     = 4;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_START  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] VS_START  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           pix_tick_c;
    logic           disp_c;
    logic           hs_raw_c;
    logic           vs_raw_c;

`ifdef VGA_PIXEL_DIV2_EN
    logic div_tog;

    // Divide-by-2 pixel tick; first tick lands on the second clk after reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) div_tog <= 1'b0;
        else      div_tog <= ~div_tog;
    end

    assign pix_tick_c = div_tog;
`else
    assign pix_tick_c = 1'b1;
`endif

    // Raster counters: h wraps every line, v advances on the h wrap.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick_c) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
            end else begin
                h_cnt <= h_cnt + H_W'(1);
            end
        end
    end

    assign disp_c   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs_raw_c = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_raw_c = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // Zero-latency coordinate side so the console can compute colour within the pixel.
    assign vga.o_h_coord     = h_cnt;
    assign vga.o_v_coord     = v_cnt;
    assign vga.o_disp_enbl   = disp_c;
    assign vga.o_frame_start = pix_tick_c && (h_cnt == '0) && (v_cnt == '0) && !arst;

    // Pin stage: colour and syncs registered together so all pins share one tick of lag.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vga.o_vga_r  <= '0;
            vga.o_vga_g  <= '0;
            vga.o_vga_b  <= '0;
            vga.o_vga_hs <= ~SYNC_POL;
            vga.o_vga_vs <= ~SYNC_POL;
        end else if (pix_tick_c) begin
            vga.o_vga_r  <= disp_c ? vga.i_red   : C_W'(0);
            vga.o_vga_g  <= disp_c ? vga.i_green : C_W'(0);
            vga.o_vga_b  <= disp_c ? vga.i_blue  : C_W'(0);
            vga.o_vga_hs <= hs_raw_c ? SYNC_POL : ~SYNC_POL;
            vga.o_vga_vs <= vs_raw_c ? SYNC_POL : ~SYNC_POL;
        end
    end
endmodule
